// File: rtl/prog_ram_loader_if.sv
// Byte-stream handshake between a program host and the loader.
interface prog_ram_loader_if;
    logic [7:0] DIN;
    logic       DIN_VALID;
    logic       DIN_READY;

    modport master (output DIN, output DIN_VALID, input DIN_READY);
    modport slave  (input DIN, input DIN_VALID, output DIN_READY);
endinterface

// File: rtl/prog_ram_loader.sv
// 16x8 writable program memory fed by a framed byte stream (header, data, checksum).
// CPU fetches through AD/Q; CPU_RUN releases it only after a verified load.
module prog_ram_loader #(
    parameter logic [7:0] FILL  = 8'h00,
    parameter logic [3:0] MAGIC = 4'hA
) (
    input  logic                CK,
    input  logic                RST,
    input  logic                START,
    prog_ram_loader_if.slave    bus,
    input  logic [3:0]          AD,
    output logic [7:0]          Q,
    output logic                CPU_RUN,
    output logic                DONE,
    output logic                ERR
);
    typedef enum logic [2:0] {IDLE, CLEAR, HDR, DATA, CSUM} state_t;

    state_t     state;
    logic [7:0] mem [16];
    logic [3:0] cnt;
    logic [3:0] len;
    logic [7:0] sum;
    logic       ready;
    logic       accept;

    assign bus.DIN_READY = ready;
    assign accept        = bus.DIN_VALID && ready;
    assign Q             = mem[AD];

    always_ff @(posedge CK) begin
        if (RST) begin
            state   <= IDLE;
            ready   <= 1'b0;
            CPU_RUN <= 1'b0;
            DONE    <= 1'b0;
            ERR     <= 1'b0;
            cnt     <= 4'd0;
            len     <= 4'd0;
            sum     <= 8'd0;
            for (int i = 0; i < 16; i++) mem[i] <= FILL;
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (START) begin
                        state   <= CLEAR;
                        ERR     <= 1'b0;
                        CPU_RUN <= 1'b0;
                        cnt     <= 4'd0;
                    end
                end
                CLEAR: begin
                    mem[cnt] <= FILL;
                    cnt      <= cnt + 4'd1;
                    // ready is registered, so raise it on the edge that leaves CLEAR
                    if (cnt == 4'd15) begin
                        state <= HDR;
                        ready <= 1'b1;
                    end
                end
                HDR: begin
                    if (accept) begin
                        if (bus.DIN[7:4] != MAGIC) begin
                            state <= IDLE;
                            ready <= 1'b0;
                            ERR   <= 1'b1;
                        end else begin
                            len   <= bus.DIN[3:0];
                            cnt   <= 4'd0;
                            sum   <= 8'd0;
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (accept) begin
                        mem[cnt] <= bus.DIN;
                        sum      <= sum + bus.DIN;
                        cnt      <= cnt + 4'd1;
                        if (cnt == len) state <= CSUM;
                    end
                end
                CSUM: begin
                    if (accept) begin
                        state <= IDLE;
                        ready <= 1'b0;
                        if (bus.DIN == sum) begin
                            DONE    <= 1'b1;
                            CPU_RUN <= 1'b1;
                        end else begin
                            ERR <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_prog_ram_loader.sv
// Directed bench for prog_ram_loader: reset, clear latency, good/bad frames, stalls, abort.
module tb_prog_ram_loader;
    logic       CK = 1'b0;
    logic       RST = 1'b0;
    logic       START = 1'b0;
    logic [3:0] AD = 4'd0;
    logic [7:0] Q;
    logic       CPU_RUN, DONE, ERR;
    int         passed = 0;
    int         total  = 0;

    prog_ram_loader_if bus ();

    prog_ram_loader dut (
        .CK(CK), .RST(RST), .START(START), .bus(bus),
        .AD(AD), .Q(Q), .CPU_RUN(CPU_RUN), .DONE(DONE), .ERR(ERR)
    );

    always #5 CK = ~CK;

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    // Present a byte and hold it until the edge that consumes it (bounded wait).
    task automatic send(input logic [7:0] b);
        int n;
        bus.DIN       = b;
        bus.DIN_VALID = 1'b1;
        n = 0;
        while (!bus.DIN_READY && n < 40) begin
            tick();
            n++;
        end
        if (!bus.DIN_READY) begin
            total++;
            $error("FAIL send_timeout: observed ready=0 expected ready=1 for byte %h", b);
        end
        tick();
    endtask

    task automatic stall(input int cycles);
        bus.DIN_VALID = 1'b0;
        repeat (cycles) tick();
    endtask

    task automatic do_start();
        START = 1'b1;
        tick();
        START = 1'b0;
    endtask

    task automatic check_mem(input string tag, input logic [7:0] exp [16]);
        for (int i = 0; i < 16; i++) begin
            AD = i[3:0];
            #1;
            chk8($sformatf("%s_q%0d", tag, i), Q, exp[i]);
        end
    endtask

    logic [7:0] good   [9]  = '{8'hA6, 8'h4C, 8'hA0, 8'hAF, 8'h11, 8'hC1, 8'hA1, 8'hB6, 8'hC4};
    logic [7:0] img    [16] = '{8'h4C, 8'hA0, 8'hAF, 8'h11, 8'hC1, 8'hA1, 8'hB6,
                                8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] zeros  [16] = '{default: 8'h00};
    logic [7:0] short_img [16] = '{0: 8'h33, default: 8'h00};

    initial begin
        bus.DIN       = 8'h00;
        bus.DIN_VALID = 1'b0;

        // reset state
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check_mem("rst", zeros);
        chk1("rst_run", CPU_RUN, 1'b0);
        chk1("rst_ready", bus.DIN_READY, 1'b0);
        chk1("rst_done", DONE, 1'b0);
        chk1("rst_err", ERR, 1'b0);

        // clear latency: ready low for 16 cycles, high on the 17th
        do_start();
        for (int i = 0; i < 16; i++) begin
            chk1($sformatf("clr_ready_c%0d", i + 1), bus.DIN_READY, 1'b0);
            tick();
        end
        chk1("clr_ready_c17", bus.DIN_READY, 1'b1);

        // good frame back-to-back
        for (int i = 0; i < 8; i++) begin
            send(good[i]);
            chk1($sformatf("good_nodone_%0d", i), DONE, 1'b0);
        end
        send(good[8]);
        bus.DIN_VALID = 1'b0;
        chk1("good_done", DONE, 1'b1);
        chk1("good_run", CPU_RUN, 1'b1);
        chk1("good_err", ERR, 1'b0);
        chk1("good_ready_off", bus.DIN_READY, 1'b0);
        tick();
        chk1("good_done_fall", DONE, 1'b0);
        chk1("good_run_hold", CPU_RUN, 1'b1);
        check_mem("good", img);

        // bad checksum; CPU_RUN drops on the reload START edge
        do_start();
        chk1("reload_run_drop", CPU_RUN, 1'b0);
        for (int i = 0; i < 8; i++) send(good[i]);
        send(8'hC5);
        bus.DIN_VALID = 1'b0;
        chk1("bcs_err", ERR, 1'b1);
        chk1("bcs_done", DONE, 1'b0);
        chk1("bcs_run", CPU_RUN, 1'b0);
        tick();
        chk1("bcs_err_sticky", ERR, 1'b1);
        chk1("bcs_done_after", DONE, 1'b0);

        // START clears ERR
        do_start();
        chk1("start_clr_err", ERR, 1'b0);

        // bad magic header
        send(8'h56);
        bus.DIN_VALID = 1'b0;
        chk1("magic_err", ERR, 1'b1);
        chk1("magic_ready", bus.DIN_READY, 1'b0);
        chk1("magic_run", CPU_RUN, 1'b0);
        // byte offered while not ready is ignored; still IDLE
        bus.DIN = 8'hA0;
        bus.DIN_VALID = 1'b1;
        repeat (3) tick();
        chk1("idle_ready", bus.DIN_READY, 1'b0);
        chk1("idle_err_hold", ERR, 1'b1);
        bus.DIN_VALID = 1'b0;

        // good frame with 3-cycle host stalls between bytes
        do_start();
        for (int i = 0; i < 9; i++) begin
            if (i != 0) stall(3);
            if (i == 8) chk1("stall_csum_ready", bus.DIN_READY, 1'b1);
            send(good[i]);
        end
        bus.DIN_VALID = 1'b0;
        chk1("stall_done", DONE, 1'b1);
        chk1("stall_run", CPU_RUN, 1'b1);
        chk1("stall_err", ERR, 1'b0);
        tick();
        chk1("stall_done_fall", DONE, 1'b0);
        check_mem("stall", img);

        // one-word frame: CLEAR must wipe words left from the previous program
        do_start();
        send(8'hA0);
        send(8'h33);
        send(8'h33);
        bus.DIN_VALID = 1'b0;
        chk1("short_done", DONE, 1'b1);
        tick();
        check_mem("short", short_img);

        // START during CLEAR ignored; RST mid-DATA aborts
        do_start();
        repeat (4) tick();
        do_start();
        repeat (10) tick();
        chk1("ign_ready_c16", bus.DIN_READY, 1'b0);
        tick();
        chk1("ign_ready_c17", bus.DIN_READY, 1'b1);
        for (int i = 0; i < 4; i++) send(good[i]);
        bus.DIN_VALID = 1'b0;
        AD = 4'd2;
        #1;
        chk8("mid_q2", Q, 8'hAF);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check_mem("abort", zeros);
        chk1("abort_ready", bus.DIN_READY, 1'b0);
        chk1("abort_done", DONE, 1'b0);
        chk1("abort_err", ERR, 1'b0);
        chk1("abort_run", CPU_RUN, 1'b0);
        repeat (20) tick();
        chk1("abort_idle_ready", bus.DIN_READY, 1'b0);
        chk1("abort_idle_done", DONE, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/prog_ram_loader.md
# prog_ram_loader

Writable 16-word × 8-bit program memory with a byte-stream loader. It is the write-side counterpart of the CPU's instruction fetch port. A host streams a framed program in over a valid/ready byte interface; the block zero-fills the memory, stores the words, and verifies a checksum. On success it releases the CPU through CPU_RUN. The CPU fetches through AD/Q exactly as it does from the fixed ROM, so this block replaces the ROM at the top level.

## Interface
- FILL, default 8'h00: word value written to every location on reset and during the CLEAR phase.
- MAGIC, default 4'hA: required value of header bits [7:4].
- CK  in  1  clock, all state updates on posedge.
- RST  in  1  synchronous, active-high reset.
- START  in  1  request a new load session; sampled only in IDLE.
- DIN  in  8  stream byte.
- DIN_VALID  in  1  DIN holds a byte.
- DIN_READY  out  1  block accepts a byte this cycle.
- AD  in  4  CPU fetch address.
- Q  out  8  instruction word; combinational mem[AD].
- CPU_RUN  out  1  high means the program is valid and the CPU may execute. Low holds the CPU in its reset/halt.
- DONE  out  1  one-cycle pulse on a successful load.
- ERR  out  1  sticky load failure; cleared by RST or by an accepted START.

## Operation
- Single clock CK. Reset is synchronous and active-high on RST.
- Byte handshake: a byte is accepted on a posedge with DIN_VALID && DIN_READY. DIN_READY is high only in HDR, DATA and CSUM. It does not depend on DIN_VALID.
- Frame format:
  - Header byte: [7:4] = MAGIC, [3:0] = N−1, giving a program length N of 1..16.
  - N data bytes, stored to words 0..N−1 in order.
  - One checksum byte, equal to (sum of the data bytes) mod 256.
- States:
  - IDLE: DIN_READY=0. If START=1, go to CLEAR; ERR←0, CPU_RUN←0, word counter←0.
  - CLEAR: write FILL to mem[counter] each cycle, counter+1. After word 15 is written, go to HDR. Occupies exactly 16 cycles.
  - HDR: on an accepted byte, if [7:4]≠MAGIC go to IDLE with ERR←1. Otherwise latch len←[3:0], counter←0, sum←0, go to DATA.
  - DATA: on an accepted byte, mem[counter]←DIN, sum←sum+DIN (8-bit wrap), counter+1. The byte where counter==len goes to CSUM.
  - CSUM: on an accepted byte, compare it with sum.
    - Equal: DONE←1 for one cycle, CPU_RUN←1, go to IDLE.
    - Unequal: ERR←1, CPU_RUN stays 0, go to IDLE.
- Words N..15 keep FILL from the CLEAR phase.
- START outside IDLE is ignored. START in IDLE while CPU_RUN=1 starts a reload, and CPU_RUN drops on that edge.
- DIN_VALID while DIN_READY=0 has no effect; the byte is not consumed.
- Q is always mem[AD], including during a load. Consumers gate on CPU_RUN.

## Timing
- Reset values on the edge where RST=1:
  - state=IDLE; DIN_READY=0, CPU_RUN=0, DONE=0, ERR=0.
  - All 16 words←FILL; counter, len and sum←0.
- RST during any state aborts the session. The memory is refilled and no DONE or ERR is produced.
- RST has priority over START and over byte acceptance.
- Latency:
  - START edge → CLEAR (16 cycles) → DIN_READY high on the 17th cycle after the START edge.
  - Minimum frame time: 1+N+1 accepted bytes at one per cycle.
  - Memory writes take effect on the accepting edge and are visible on Q in the next cycle.
- DONE and CPU_RUN rise on the edge that accepts a good checksum. DONE falls the following edge.
- ERR rises on the edge accepting a bad header or a bad checksum.
- Host stalls (DIN_VALID=0) may occur in any receiving state for any number of cycles. State is held.

## Test plan
- After RST, Q=8'h00 for all AD; CPU_RUN=0, DIN_READY=0. Pulse START: DIN_READY=0 for 16 cycles, then 1.
- Load A6,4C,A0,AF,11,C1,A1,B6,C4 back-to-back:
  - DONE pulses once and CPU_RUN=1.
  - Q at AD=0..6 reads 4C,A0,AF,11,C1,A1,B6; AD=7..15 reads 00.
- Same frame with checksum C5 → ERR=1, DONE never pulses, CPU_RUN=0. A subsequent START clears ERR.
- Header 8'h56 (bad magic) → ERR=1 on that edge, return to IDLE, DIN_READY=0.
- Same good frame with DIN_VALID low for 3 cycles between every byte → identical final memory and DONE.
- RST asserted mid-DATA after 3 data bytes → all words 00, state IDLE, no DONE or ERR. START pulsed during CLEAR → ignored.
